// File: rtl/slave_rx_frontend.sv
// slave_rx_frontend
// Bus-side receive front end for the I2C slave. Synchronises and glitch-filters
// raw SCL/SDA, detects START/STOP, and deserialises the address byte and any
// master-written data bytes.
//
// Ports:
//   fpga_clk         system clock, rising edge
//   slave_reset      asynchronous active-low reset
//   scl_in, sda_in   raw bus pin levels
//   slave_scl_sixt   filtered SCL (clocks the downstream slave FSM)
//   slave_start_bit  active-low START flag, held through the first SCL fall
//   slave_stop_det   one-cycle pulse on STOP
//   slave_addr_rcvd  last 7-bit address received
//   slave_rd_wr      R/W bit of the last address byte (1 = read)
//   slave_data_rcvd  last complete master-written data byte
//   slave_data_valid one-cycle pulse when slave_data_rcvd updates
//   slave_ack        SDA sampled at the most recent ACK-slot SCL rise
//   slave_busy       high between START and STOP
module slave_rx_frontend #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       fpga_clk,
    input  logic       slave_reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       slave_scl_sixt,
    output logic       slave_start_bit,
    output logic       slave_stop_det,
    output logic [6:0] slave_addr_rcvd,
    output logic       slave_rd_wr,
    output logic [7:0] slave_data_rcvd,
    output logic       slave_data_valid,
    output logic       slave_ack,
    output logic       slave_busy
);

    localparam logic [3:0] FILT_MAX = 4'(FILT_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_DATA,
        S_DATA_ACK
    } bus_state_t;

    bus_state_t state, state_next;

    logic       scl_s1, scl_s2, sda_s1, sda_s2;
    logic       scl_filt, sda_filt, scl_d, sda_d;
    logic [3:0] scl_cnt, sda_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] shift_in;
    logic       scl_rise, scl_fall, sda_rise, sda_fall;
    logic       start_cond, stop_cond, last_bit;

    // Two-flop synchronisers; idle bus level is high, so they reset to 1.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values and the chain behaves as a real shift register.
    always_ff @(posedge fpga_clk or negedge slave_reset) begin
        if (!slave_reset) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
        end
    end

    // Glitch filters: a line flips only after FILT_LEN consecutive disagreeing
    // samples; any agreeing sample restarts the count.
    always_ff @(posedge fpga_clk or negedge slave_reset) begin
        if (!slave_reset) begin
            scl_filt <= 1'b1;
            scl_cnt  <= '0;
            sda_filt <= 1'b1;
            sda_cnt  <= '0;
        end else begin
            if (scl_s2 != scl_filt) begin
                if (scl_cnt == FILT_MAX - 4'd1) begin
                    scl_filt <= ~scl_filt;
                    scl_cnt  <= '0;
                end else begin
                    scl_cnt <= scl_cnt + 4'd1;
                end
            end else begin
                scl_cnt <= '0;
            end

            if (sda_s2 != sda_filt) begin
                if (sda_cnt == FILT_MAX - 4'd1) begin
                    sda_filt <= ~sda_filt;
                    sda_cnt  <= '0;
                end else begin
                    sda_cnt <= sda_cnt + 4'd1;
                end
            end else begin
                sda_cnt <= '0;
            end
        end
    end

    always_ff @(posedge fpga_clk or negedge slave_reset) begin
        if (!slave_reset) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_filt;
            sda_d <= sda_filt;
        end
    end

    assign scl_rise = scl_filt & ~scl_d;
    assign scl_fall = ~scl_filt & scl_d;
    assign sda_rise = sda_filt & ~sda_d;
    assign sda_fall = ~sda_filt & sda_d;

    // SCL must be high now and in the previous cycle, so a coincident SCL edge
    // suppresses the condition.
    assign start_cond = scl_filt & scl_d & sda_fall;
    assign stop_cond  = scl_filt & scl_d & sda_rise;

    assign shift_in = {shift_reg[6:0], sda_filt};
    assign last_bit = (bit_cnt == 3'd7);

    always_ff @(posedge fpga_clk or negedge slave_reset) begin
        if (!slave_reset) state <= S_IDLE;
        else              state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        if (start_cond) begin
            state_next = S_ADDR;
        end else if (stop_cond) begin
            state_next = S_IDLE;
        end else if (scl_rise) begin
            case (state)
                S_ADDR:     if (last_bit) state_next = S_ADDR_ACK;
                S_ADDR_ACK: state_next = S_DATA;
                S_DATA:     if (last_bit) state_next = S_DATA_ACK;
                S_DATA_ACK: state_next = S_DATA;
                default:    state_next = state;
            endcase
        end
    end

    // Datapath: shift register, bit counter and registered outputs.
    always_ff @(posedge fpga_clk or negedge slave_reset) begin
        if (!slave_reset) begin
            bit_cnt          <= '0;
            shift_reg        <= '0;
            slave_start_bit  <= 1'b1;
            slave_stop_det   <= 1'b0;
            slave_addr_rcvd  <= '0;
            slave_rd_wr      <= 1'b0;
            slave_data_rcvd  <= '0;
            slave_data_valid <= 1'b0;
            slave_ack        <= 1'b1;
        end else begin
            slave_stop_det   <= stop_cond;
            slave_data_valid <= 1'b0;

            // Held low from START until the first SCL fall so the FSM, which
            // runs on slave_scl_sixt, sees it at its first negedge.
            if (start_cond)
                slave_start_bit <= 1'b0;
            else if (stop_cond || scl_fall)
                slave_start_bit <= 1'b1;

            if (start_cond || stop_cond) begin
                bit_cnt   <= '0;
                shift_reg <= '0;
            end else if (scl_rise) begin
                case (state)
                    S_ADDR: begin
                        shift_reg <= shift_in;
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (last_bit) begin
                            slave_addr_rcvd <= shift_in[7:1];
                            slave_rd_wr     <= shift_in[0];
                        end
                    end
                    S_ADDR_ACK, S_DATA_ACK: begin
                        slave_ack <= sda_filt;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                    end
                    S_DATA: begin
                        bit_cnt <= bit_cnt + 3'd1;
                        // On reads the master is not driving data: count only.
                        if (!slave_rd_wr) begin
                            shift_reg <= shift_in;
                            if (last_bit) begin
                                slave_data_rcvd  <= shift_in;
                                slave_data_valid <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign slave_scl_sixt = scl_filt;
    assign slave_busy     = (state != S_IDLE);

endmodule

// File: tb/tb_slave_rx_frontend.sv
// Directed testbench for slave_rx_frontend (FILT_LEN = 3).
module tb_slave_rx_frontend;

    logic       fpga_clk;
    logic       slave_reset;
    logic       scl_in;
    logic       sda_in;
    logic       slave_scl_sixt;
    logic       slave_start_bit;
    logic       slave_stop_det;
    logic [6:0] slave_addr_rcvd;
    logic       slave_rd_wr;
    logic [7:0] slave_data_rcvd;
    logic       slave_data_valid;
    logic       slave_ack;
    logic       slave_busy;

    int checks = 0;
    int fails  = 0;
    int stop_cnt  = 0;
    int valid_cnt = 0;

    slave_rx_frontend #(.FILT_LEN(3)) dut (
        .fpga_clk        (fpga_clk),
        .slave_reset     (slave_reset),
        .scl_in          (scl_in),
        .sda_in          (sda_in),
        .slave_scl_sixt  (slave_scl_sixt),
        .slave_start_bit (slave_start_bit),
        .slave_stop_det  (slave_stop_det),
        .slave_addr_rcvd (slave_addr_rcvd),
        .slave_rd_wr     (slave_rd_wr),
        .slave_data_rcvd (slave_data_rcvd),
        .slave_data_valid(slave_data_valid),
        .slave_ack       (slave_ack),
        .slave_busy      (slave_busy)
    );

    initial fpga_clk = 1'b0;
    always #5 fpga_clk = ~fpga_clk;

    // Pulse counters sampled on the falling edge, away from output updates.
    always @(negedge fpga_clk) begin
        if (slave_stop_det)   stop_cnt  <= stop_cnt + 1;
        if (slave_data_valid) valid_cnt <= valid_cnt + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge fpga_clk);
        #1;
    endtask

    // One bit with SCL starting and ending low; glen > 0 injects a SCL low
    // glitch of that many cycles in the middle of the high phase.
    task automatic send_bit_g(input logic b, input int glen);
        sda_in = b;
        cyc(5);
        scl_in = 1'b1;
        if (glen > 0) begin
            cyc(6);
            scl_in = 1'b0;
            cyc(glen);
            scl_in = 1'b1;
        end
        cyc(10);
        scl_in = 1'b0;
        cyc(5);
    endtask

    task automatic send_bit(input logic b);
        send_bit_g(b, 0);
    endtask

    task automatic send_byte_g(input logic [7:0] v, input int gidx, input int glen);
        for (int i = 7; i >= 0; i--)
            send_bit_g(v[i], (7 - i == gidx) ? glen : 0);
    endtask

    task automatic send_byte(input logic [7:0] v);
        send_byte_g(v, 8, 0);
    endtask

    task automatic do_start();
        if (!scl_in) begin
            sda_in = 1'b1;
            cyc(5);
            scl_in = 1'b1;
            cyc(10);
        end
        sda_in = 1'b0;
        cyc(10);
        scl_in = 1'b0;
        cyc(7);
    endtask

    task automatic do_stop();
        sda_in = 1'b0;
        cyc(5);
        scl_in = 1'b1;
        cyc(10);
        sda_in = 1'b1;
        cyc(10);
    endtask

    task automatic test_reset();
        slave_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            scl_in = 1'($urandom_range(0, 1));
            sda_in = 1'($urandom_range(0, 1));
            cyc(1);
        end
        checks++; if (slave_scl_sixt !== 1'b1) begin fails++; $display("FAIL rst_scl_sixt got=%b exp=1", slave_scl_sixt); end
        checks++; if (slave_start_bit !== 1'b1) begin fails++; $display("FAIL rst_start_bit got=%b exp=1", slave_start_bit); end
        checks++; if (slave_stop_det !== 1'b0) begin fails++; $display("FAIL rst_stop_det got=%b exp=0", slave_stop_det); end
        checks++; if (slave_addr_rcvd !== 7'h00) begin fails++; $display("FAIL rst_addr got=%h exp=00", slave_addr_rcvd); end
        checks++; if (slave_rd_wr !== 1'b0) begin fails++; $display("FAIL rst_rd_wr got=%b exp=0", slave_rd_wr); end
        checks++; if (slave_data_rcvd !== 8'h00) begin fails++; $display("FAIL rst_data got=%h exp=00", slave_data_rcvd); end
        checks++; if (slave_data_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", slave_data_valid); end
        checks++; if (slave_ack !== 1'b1) begin fails++; $display("FAIL rst_ack got=%b exp=1", slave_ack); end
        checks++; if (slave_busy !== 1'b0) begin fails++; $display("FAIL rst_busy got=%b exp=0", slave_busy); end
        scl_in = 1'b1;
        sda_in = 1'b1;
        cyc(2);
        slave_reset = 1'b1;
        cyc(30);
        checks++; if (stop_cnt !== 0) begin fails++; $display("FAIL rel_stop_cnt got=%0d exp=0", stop_cnt); end
        checks++; if (slave_busy !== 1'b0) begin fails++; $display("FAIL rel_busy got=%b exp=0", slave_busy); end
    endtask

    task automatic test_addr_write();
        sda_in = 1'b0;
        cyc(10);
        checks++; if (slave_start_bit !== 1'b0) begin fails++; $display("FAIL aw_start_low got=%b exp=0", slave_start_bit); end
        checks++; if (slave_busy !== 1'b1) begin fails++; $display("FAIL aw_busy_start got=%b exp=1", slave_busy); end
        scl_in = 1'b0;
        cyc(3);
        checks++; if (slave_start_bit !== 1'b0) begin fails++; $display("FAIL aw_start_held got=%b exp=0", slave_start_bit); end
        cyc(4);
        checks++; if (slave_start_bit !== 1'b1) begin fails++; $display("FAIL aw_start_release got=%b exp=1", slave_start_bit); end
        send_byte(8'hF4);
        checks++; if (slave_addr_rcvd !== 7'h7A) begin fails++; $display("FAIL aw_addr got=%h exp=7a", slave_addr_rcvd); end
        checks++; if (slave_rd_wr !== 1'b0) begin fails++; $display("FAIL aw_rd_wr got=%b exp=0", slave_rd_wr); end
        send_bit(1'b0);
        checks++; if (slave_ack !== 1'b0) begin fails++; $display("FAIL aw_ack got=%b exp=0", slave_ack); end
        checks++; if (slave_busy !== 1'b1) begin fails++; $display("FAIL aw_busy got=%b exp=1", slave_busy); end
    endtask

    task automatic test_write_data();
        int v0, s0;
        v0 = valid_cnt;
        s0 = stop_cnt;
        send_byte(8'hA5);
        checks++; if (slave_data_rcvd !== 8'hA5) begin fails++; $display("FAIL wd_byte0 got=%h exp=a5", slave_data_rcvd); end
        checks++; if (valid_cnt - v0 !== 1) begin fails++; $display("FAIL wd_valid0 got=%0d exp=1", valid_cnt - v0); end
        send_bit(1'b0);
        send_byte(8'h3C);
        checks++; if (slave_data_rcvd !== 8'h3C) begin fails++; $display("FAIL wd_byte1 got=%h exp=3c", slave_data_rcvd); end
        send_bit(1'b0);
        do_stop();
        checks++; if (valid_cnt - v0 !== 2) begin fails++; $display("FAIL wd_valid_total got=%0d exp=2", valid_cnt - v0); end
        checks++; if (stop_cnt - s0 !== 1) begin fails++; $display("FAIL wd_stop got=%0d exp=1", stop_cnt - s0); end
        checks++; if (slave_busy !== 1'b0) begin fails++; $display("FAIL wd_busy got=%b exp=0", slave_busy); end
    endtask

    task automatic test_read_nack();
        int v0;
        v0 = valid_cnt;
        do_start();
        send_byte(8'hF5);
        checks++; if (slave_addr_rcvd !== 7'h7A) begin fails++; $display("FAIL rd_addr got=%h exp=7a", slave_addr_rcvd); end
        checks++; if (slave_rd_wr !== 1'b1) begin fails++; $display("FAIL rd_rd_wr got=%b exp=1", slave_rd_wr); end
        send_bit(1'b0);
        checks++; if (slave_ack !== 1'b0) begin fails++; $display("FAIL rd_addr_ack got=%b exp=0", slave_ack); end
        send_byte(8'hFF);
        send_bit(1'b1);
        checks++; if (slave_ack !== 1'b1) begin fails++; $display("FAIL rd_nack got=%b exp=1", slave_ack); end
        checks++; if (valid_cnt - v0 !== 0) begin fails++; $display("FAIL rd_valid got=%0d exp=0", valid_cnt - v0); end
        checks++; if (slave_data_rcvd !== 8'h3C) begin fails++; $display("FAIL rd_data_kept got=%h exp=3c", slave_data_rcvd); end
        do_stop();
    endtask

    task automatic test_glitch();
        // 2-cycle glitch: filtered out, 0xB4 arrives intact.
        do_start();
        send_byte_g(8'hB4, 3, 2);
        checks++; if (slave_addr_rcvd !== 7'h5A) begin fails++; $display("FAIL gl2_addr got=%h exp=5a", slave_addr_rcvd); end
        checks++; if (slave_rd_wr !== 1'b0) begin fails++; $display("FAIL gl2_rd_wr got=%b exp=0", slave_rd_wr); end
        send_bit(1'b0);
        do_stop();
        // 3-cycle glitch on bit 2 (value 1) of 0x2C: extra rise duplicates the
        // 1, the 8th rise lands on raw bit 6 -> 0011_0110 = 0x36.
        do_start();
        send_byte_g(8'h2C, 2, 3);
        checks++; if (slave_addr_rcvd !== 7'h1B) begin fails++; $display("FAIL gl3_addr got=%h exp=1b", slave_addr_rcvd); end
        checks++; if (slave_ack !== 1'b0) begin fails++; $display("FAIL gl3_ack got=%b exp=0", slave_ack); end
        do_stop();
    endtask

    task automatic test_abort_rstart();
        do_start();
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        do_start();
        checks++; if (slave_busy !== 1'b1) begin fails++; $display("FAIL rs_busy got=%b exp=1", slave_busy); end
        send_byte(8'h66);
        checks++; if (slave_addr_rcvd !== 7'h33) begin fails++; $display("FAIL rs_addr got=%h exp=33", slave_addr_rcvd); end
        checks++; if (slave_rd_wr !== 1'b0) begin fails++; $display("FAIL rs_rd_wr got=%b exp=0", slave_rd_wr); end
        send_bit(1'b0);
        do_stop();
    endtask

    task automatic test_abort_stop();
        int v0, s0;
        do_start();
        send_byte(8'h20);
        send_bit(1'b0);
        v0 = valid_cnt;
        s0 = stop_cnt;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        do_stop();
        checks++; if (valid_cnt - v0 !== 0) begin fails++; $display("FAIL ps_valid got=%0d exp=0", valid_cnt - v0); end
        checks++; if (stop_cnt - s0 !== 1) begin fails++; $display("FAIL ps_stop got=%0d exp=1", stop_cnt - s0); end
        checks++; if (slave_busy !== 1'b0) begin fails++; $display("FAIL ps_busy got=%b exp=0", slave_busy); end
        checks++; if (slave_data_rcvd !== 8'h3C) begin fails++; $display("FAIL ps_data got=%h exp=3c", slave_data_rcvd); end
    endtask

    task automatic test_abort_reset();
        int v0, s0;
        do_start();
        send_byte(8'hF4);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        slave_reset = 1'b0;
        cyc(1);
        checks++; if (slave_addr_rcvd !== 7'h00) begin fails++; $display("FAIL mr_addr got=%h exp=00", slave_addr_rcvd); end
        checks++; if (slave_data_rcvd !== 8'h00) begin fails++; $display("FAIL mr_data got=%h exp=00", slave_data_rcvd); end
        checks++; if (slave_ack !== 1'b1) begin fails++; $display("FAIL mr_ack got=%b exp=1", slave_ack); end
        checks++; if (slave_busy !== 1'b0) begin fails++; $display("FAIL mr_busy got=%b exp=0", slave_busy); end
        checks++; if (slave_start_bit !== 1'b1) begin fails++; $display("FAIL mr_start_bit got=%b exp=1", slave_start_bit); end
        checks++; if (slave_scl_sixt !== 1'b1) begin fails++; $display("FAIL mr_scl_sixt got=%b exp=1", slave_scl_sixt); end
        // Bus activity without a START after release must be ignored.
        sda_in = 1'b1;
        cyc(3);
        slave_reset = 1'b1;
        v0 = valid_cnt;
        s0 = stop_cnt;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        scl_in = 1'b1;
        cyc(20);
        checks++; if (slave_busy !== 1'b0) begin fails++; $display("FAIL pr_busy got=%b exp=0", slave_busy); end
        checks++; if (slave_addr_rcvd !== 7'h00) begin fails++; $display("FAIL pr_addr got=%h exp=00", slave_addr_rcvd); end
        checks++; if (valid_cnt - v0 !== 0) begin fails++; $display("FAIL pr_valid got=%0d exp=0", valid_cnt - v0); end
        checks++; if (stop_cnt - s0 !== 0) begin fails++; $display("FAIL pr_stop got=%0d exp=0", stop_cnt - s0); end
    endtask

    initial begin
        slave_reset = 1'b0;
        scl_in      = 1'b1;
        sda_in      = 1'b1;
        cyc(2);
        test_reset();
        test_addr_write();
        test_write_data();
        test_read_nack();
        test_glitch();
        test_abort_rstart();
        test_abort_stop();
        test_abort_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/slave_rx_frontend.md
# slave_rx_frontend

Bus-side receive front end for the I2C slave. It samples raw SCL/SDA on `fpga_clk`, synchronises and glitch-filters both lines, and produces the clean `slave_scl_sixt` that clocks the slave FSM. It detects START/STOP and deserialises the address byte into `slave_addr_rcvd`/`slave_rd_wr`, and master-written data bytes into `slave_data_rcvd`. It sits directly upstream of the slave FSM, which consumes `slave_scl_sixt`, `slave_start_bit`, `slave_addr_rcvd`, `slave_rd_wr` and `slave_ack`.

## Interface
- `FILT_LEN`, default 3: consecutive identical synchronised samples required before a filtered line changes level (range 1..15).
- `fpga_clk` in 1: system clock, rising-edge.
- `slave_reset` in 1: asynchronous, active-low reset.
- `scl_in` in 1: raw SCL pin level.
- `sda_in` in 1: raw SDA pin level.
- `slave_scl_sixt` out 1: filtered SCL; clocks the slave FSM.
- `slave_start_bit` out 1: active-low START indication.
- `slave_stop_det` out 1: one-cycle pulse on STOP.
- `slave_addr_rcvd` out 7: last received 7-bit address.
- `slave_rd_wr` out 1: R/W bit of the last address byte (1 = read).
- `slave_data_rcvd` out 8: last complete master-written data byte.
- `slave_data_valid` out 1: one-cycle pulse when `slave_data_rcvd` updates.
- `slave_ack` out 1: SDA sampled at the most recent ACK-slot SCL rise (0 = ACK).
- `slave_busy` out 1: high between START and STOP.

## Operation
- Synchroniser: 2-flop on each of `scl_in` and `sda_in`.
- Filter:
  - Per line, a 4-bit counter counts cycles where the synchronised value differs from the filtered value.
  - When the counter reaches FILT_LEN, the filtered value flips and the counter clears. Any agreeing sample clears the counter.
  - Both filtered values reset to 1.
- Edge detect on filtered lines gives single-cycle `scl_rise`, `scl_fall`, `sda_fall`, `sda_rise`.
- Condition detect, only when filtered SCL = 1 and no SCL edge in the same cycle:
  - START: `sda_fall`.
  - STOP: `sda_rise`.
  - If an SCL edge and an SDA edge coincide, the SCL edge wins and no condition is flagged.
- Bus FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK.
  - START (including repeated START) from any state → ADDR: bit counter cleared to 0, shift register cleared, `slave_busy` = 1, partial byte discarded.
  - STOP from any state → IDLE: `slave_stop_det` pulses, `slave_busy` = 0, partial byte discarded with no `slave_data_valid`.
  - ADDR: each `scl_rise` shifts SDA into the shift register, MSB first, and increments the counter. On the 8th rise, `slave_addr_rcvd` ← bits[7:1] and `slave_rd_wr` ← bit[0], both registered on that cycle; go to ADDR_ACK.
  - ADDR_ACK: the next `scl_rise` samples SDA into `slave_ack`. Then go to DATA, with counter and shift register cleared.
  - DATA: shifts as in ADDR only when `slave_rd_wr` = 0. On the 8th rise, `slave_data_rcvd` updates and `slave_data_valid` pulses; go to DATA_ACK. When `slave_rd_wr` = 1, rises are counted but no data is shifted, and `slave_data_rcvd` and `slave_data_valid` stay unchanged.
  - DATA_ACK: the 9th rise samples SDA into `slave_ack`, then DATA again. Unlimited bytes per transfer.
  - SCL edges in IDLE are ignored.
- `slave_start_bit`:
  - Driven 0 on the cycle after START is detected.
  - Held 0 through the first subsequent `scl_fall`; returns to 1 on the cycle after that fall. This guarantees the FSM samples 0 at its first negedge.
  - A STOP while it is held forces it back to 1.
- Reset values: `slave_scl_sixt` = 1, `slave_start_bit` = 1, `slave_stop_det` = 0, `slave_addr_rcvd` = 0, `slave_rd_wr` = 0, `slave_data_rcvd` = 0, `slave_data_valid` = 0, `slave_ack` = 1, `slave_busy` = 0, FSM = IDLE, counters = 0.
- Reset asserted mid-transfer returns everything to reset values immediately. After release, the block waits for a fresh START; SDA/SCL activity before that START is ignored.

## Timing
- Pin to filtered level: 2 (sync) + FILT_LEN cycles. `slave_scl_sixt` therefore lags `scl_in` by FILT_LEN+2 cycles, and SDA lags by the same amount, so relative SCL/SDA timing is preserved.
- Edge pulses: 1 cycle after the filtered change.
- START/STOP registered outputs: 1 cycle after the edge pulse.
- `slave_addr_rcvd`, `slave_rd_wr`, `slave_data_rcvd`, `slave_ack`: updated 1 cycle after the relevant `scl_rise` pulse, i.e. before the following SCL fall, given SCL high ≥ FILT_LEN+4 cycles.
- Minimum supported SCL high/low time: FILT_LEN+4 `fpga_clk` cycles.
- Pulses shorter than FILT_LEN cycles on either line never reach the filtered outputs.

## Test plan
- Reset: hold `slave_reset` = 0 with random pins → all outputs at reset values. Release with SCL = SDA = 1 → no `slave_stop_det` and no `slave_busy`.
- Address write: START, byte 0xF4 (address 0x7A, W), ACK = 0 → `slave_start_bit` low until the 1st SCL fall, `slave_addr_rcvd` = 7'h7A, `slave_rd_wr` = 0, `slave_ack` = 0, `slave_busy` = 1.
- Write data: following on from the address write, bytes 0xA5 then 0x3C, then STOP → `slave_data_valid` pulses exactly twice, `slave_data_rcvd` = 0xA5 then 0x3C, then `slave_stop_det` pulse and `slave_busy` = 0.
- Read with NACK: START, 0xF5 (address 0x7A, R), 8 clocks with SDA = 1, then NACK → `slave_rd_wr` = 1, no `slave_data_valid`, `slave_ack` = 1 after the 9th rise.
- Glitch filter: with FILT_LEN = 3, inject a 2-cycle SCL low glitch mid-byte → no extra shift and the byte is received intact. A 3-cycle glitch → counted as a real edge.
- Aborts:
  - Repeated START after 4 address bits → partial discarded; the next 8 bits give the new address.
  - STOP mid-data byte → no `slave_data_valid`.
  - Reset mid-byte → outputs at reset values next cycle.
